// File: rtl/cam_csr_mc.sv
// CPU-side CSR block for the multi-channel camera packet receiver: config, interrupts, page read-out.
// Optional per-channel lost-packet counters are enabled with `define CAM_CSR_LOST_CNT_EN.
module cam_csr_mc #(
   parameter logic [7:0] VERSION = 8'h20,
   parameter int         CH_NUM  = 2,
   parameter int         ADDR_W  = 8,
   parameter int         FLAG_W  = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   output logic                       irq,
   input  logic                       chip_select,
   input  logic [4:0]                 csr_address,
   input  logic                       csr_read,
   output logic [7:0]                 csr_readdata,
   input  logic                       csr_write,
   input  logic [7:0]                 csr_writedata,
   output logic [1:0]                 rx_ch_sel,
   output logic [ADDR_W-1:0]          rx_ram_rd_addr,
   output logic [CH_NUM-1:0]          rx_ram_rd_done,
   output logic [CH_NUM-1:0]          rx_clean_all,
   input  logic [CH_NUM*8-1:0]        rx_ram_rd_byte,
   input  logic [CH_NUM*FLAG_W-1:0]   rx_ram_rd_flags,
   input  logic [CH_NUM-1:0]          rx_ram_lost,
   input  logic [CH_NUM-1:0]          rx_pending,
   output logic [7:0]                 pkt_size
);

   localparam logic [4:0] A_VERSION  = 5'h00;
   localparam logic [4:0] A_SETTING  = 5'h02;
   localparam logic [4:0] A_PKT_SIZE = 5'h04;
   localparam logic [4:0] A_INT_FLAG = 5'h10;
   localparam logic [4:0] A_INT_MASK = 5'h11;
   localparam logic [4:0] A_RX       = 5'h14;
   localparam logic [4:0] A_RX_CTRL  = 5'h16;
   localparam logic [4:0] A_ADDR_LO  = 5'h18;
   localparam logic [4:0] A_PAGE_FLG = 5'h19;
   localparam logic [4:0] A_ADDR_HI  = 5'h1A;
   localparam logic [4:0] A_LOST_CNT = 5'h1C;

   logic                r_cs_d;
   logic [1:0]          r_ch_sel;
   logic                r_auto_done;
   logic [7:0]          r_pkt_size;
   logic [7:0]          r_int_mask;
   logic [7:0]          r_int_snap;
   logic [CH_NUM-1:0]   r_lost;
   logic [CH_NUM-1:0]   r_rd_done;
   logic [CH_NUM-1:0]   r_clean;
   logic [ADDR_W-1:0]   r_addr;
   logic [FLAG_W-1:0]   r_flag_sr;

   logic [7:0]          w_bytes [4];
   logic [FLAG_W-1:0]   w_flags [4];
   logic [7:0]          w_int_flag;
   logic [3:0]          w_lost4;
   logic                w_wr;
   logic                w_rd;
   logic                w_ctrl_wr;
   logic [1:0]          w_sel_wr;
   logic                w_sel_chg;
   logic                w_auto_rel;
   logic [CH_NUM-1:0]   w_sel_onehot;
   logic [CH_NUM-1:0]   w_lost_clr;
   logic [ADDR_W-1:0]   w_addr_next;
   logic [7:0]          w_rdata;
   logic [7:0]          w_lost_cnt_rd;

   // Pad per-channel buses to four entries so ch_sel can index them directly.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_pad
         if (gi < CH_NUM) begin : g_live
            assign w_bytes[gi] = rx_ram_rd_byte[gi*8 +: 8];
            assign w_flags[gi] = rx_ram_rd_flags[gi*FLAG_W +: FLAG_W];
         end else begin : g_none
            assign w_bytes[gi] = 8'h00;
            assign w_flags[gi] = '0;
         end
      end
   endgenerate

   assign w_lost4      = 4'(rx_ram_lost);
   assign w_int_flag   = {4'(r_lost), 4'(rx_pending)};
   assign w_wr         = chip_select & csr_write;
   assign w_rd         = chip_select & csr_read;
   assign w_ctrl_wr    = w_wr && (csr_address == A_RX_CTRL);
   assign w_sel_wr     = (32'(csr_writedata[1:0]) >= CH_NUM) ? 2'(CH_NUM - 1) : csr_writedata[1:0];
   assign w_sel_chg    = w_wr && (csr_address == A_SETTING) && (w_sel_wr != r_ch_sel);
   assign w_auto_rel   = r_cs_d & ~chip_select & r_auto_done & (r_addr != '0);
   assign w_sel_onehot = CH_NUM'(1) << r_ch_sel;
   // Only lost bits the CPU actually saw in the snapshot are acknowledged.
   assign w_lost_clr   = (w_rd && (csr_address == A_INT_FLAG)) ? r_int_snap[4 +: CH_NUM] : '0;

   assign irq            = |(w_int_flag & r_int_mask);
   assign rx_ch_sel      = r_ch_sel;
   assign rx_ram_rd_addr = r_addr;
   assign rx_ram_rd_done = r_rd_done;
   assign rx_clean_all   = r_clean;
   assign pkt_size       = r_pkt_size;
   assign csr_readdata   = w_rdata;

   // Later assignments win: explicit address writes beat auto-release, which beats the read increment.
   always_comb begin
      w_addr_next = r_addr;
      if (w_rd && (csr_address == A_RX))
         w_addr_next = r_addr + ADDR_W'(1);
      if (w_auto_rel || w_sel_chg)
         w_addr_next = '0;
      if (w_ctrl_wr && csr_writedata[0])
         w_addr_next = '0;
      if (w_wr && (csr_address == A_ADDR_LO))
         w_addr_next = ADDR_W'({8'(r_addr >> 8), csr_writedata});
      if (w_wr && (csr_address == A_ADDR_HI))
         w_addr_next = ADDR_W'({csr_writedata, r_addr[7:0]});
   end

   always_comb begin
      w_rdata = 8'h00;
      case (csr_address)
         A_VERSION:  w_rdata = VERSION;
         A_SETTING:  w_rdata = {r_auto_done, 5'b00000, r_ch_sel};
         A_PKT_SIZE: w_rdata = r_pkt_size;
         A_INT_FLAG: w_rdata = r_int_snap;
         A_INT_MASK: w_rdata = r_int_mask;
         A_RX:       w_rdata = w_bytes[r_ch_sel];
         A_ADDR_LO:  w_rdata = r_addr[7:0];
         A_PAGE_FLG: w_rdata = r_flag_sr[7:0];
         A_ADDR_HI:  w_rdata = 8'(r_addr >> 8);
         A_LOST_CNT: w_rdata = w_lost_cnt_rd;
         default:    w_rdata = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cs_d      <= 1'b0;
         r_ch_sel    <= 2'd0;
         r_auto_done <= 1'b1;
         r_pkt_size  <= 8'd249;
         r_int_mask  <= 8'h00;
         r_int_snap  <= 8'h00;
         r_lost      <= '0;
         r_rd_done   <= '0;
         r_clean     <= '0;
         r_addr      <= '0;
         r_flag_sr   <= '0;
      end else begin
         r_cs_d <= chip_select;
         r_addr <= w_addr_next;
         r_lost <= rx_ram_lost | (r_lost & ~w_lost_clr);

         if (w_wr && (csr_address == A_SETTING)) begin
            r_ch_sel    <= w_sel_wr;
            r_auto_done <= csr_writedata[7];
         end
         if (w_wr && (csr_address == A_PKT_SIZE))
            r_pkt_size <= csr_writedata;
         if (w_wr && (csr_address == A_INT_MASK))
            r_int_mask <= csr_writedata;

         // Snapshots track live state between transactions and freeze for the CPU's view.
         if (!chip_select) begin
            r_int_snap <= w_int_flag;
            r_flag_sr  <= w_flags[r_ch_sel];
         end else if (w_rd && (csr_address == A_PAGE_FLG)) begin
            r_flag_sr  <= r_flag_sr >> 8;
         end

         r_rd_done <= (w_auto_rel || (w_ctrl_wr && csr_writedata[1])) ? w_sel_onehot : '0;
         if (w_ctrl_wr && csr_writedata[5])
            r_clean <= '1;
         else if (w_ctrl_wr && csr_writedata[4])
            r_clean <= w_sel_onehot;
         else
            r_clean <= '0;
      end
   end

`ifdef CAM_CSR_LOST_CNT_EN
   logic [7:0] r_lost_cnt [4];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++)
            r_lost_cnt[i] <= 8'h00;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (i >= CH_NUM)
               r_lost_cnt[i] <= 8'h00;
            else if (w_wr && (csr_address == A_LOST_CNT) && (r_ch_sel == 2'(i)))
               r_lost_cnt[i] <= {7'd0, w_lost4[i]};
            else if (w_lost4[i] && (r_lost_cnt[i] != 8'hFF))
               r_lost_cnt[i] <= r_lost_cnt[i] + 8'd1;
         end
      end
   end

   assign w_lost_cnt_rd = r_lost_cnt[r_ch_sel];
`else
   assign w_lost_cnt_rd = 8'h00;
`endif

endmodule

// File: tb/tb_cam_csr_mc.sv
// Self-checking bench for cam_csr_mc with CH_NUM=2, ADDR_W=10, FLAG_W=16.
// Register table first, then hand-written sequences for the multi-cycle corner cases.
module tb_cam_csr_mc;
   localparam int CH_NUM = 2;
   localparam int ADDR_W = 10;
   localparam int FLAG_W = 16;

   logic                     clk;
   logic                     reset_n;
   logic                     irq;
   logic                     chip_select;
   logic [4:0]               csr_address;
   logic                     csr_read;
   logic [7:0]               csr_readdata;
   logic                     csr_write;
   logic [7:0]               csr_writedata;
   logic [1:0]               rx_ch_sel;
   logic [ADDR_W-1:0]        rx_ram_rd_addr;
   logic [CH_NUM-1:0]        rx_ram_rd_done;
   logic [CH_NUM-1:0]        rx_clean_all;
   logic [CH_NUM*8-1:0]      rx_ram_rd_byte;
   logic [CH_NUM*FLAG_W-1:0] rx_ram_rd_flags;
   logic [CH_NUM-1:0]        rx_ram_lost;
   logic [CH_NUM-1:0]        rx_pending;
   logic [7:0]               pkt_size;

   int errors = 0;
   int checks = 0;
   int mon_done = 0;
   logic [7:0] exp_q[$];

   cam_csr_mc #(.VERSION(8'h20), .CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .FLAG_W(FLAG_W)) dut (
      .clk(clk), .reset_n(reset_n), .irq(irq), .chip_select(chip_select),
      .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
      .csr_write(csr_write), .csr_writedata(csr_writedata), .rx_ch_sel(rx_ch_sel),
      .rx_ram_rd_addr(rx_ram_rd_addr), .rx_ram_rd_done(rx_ram_rd_done),
      .rx_clean_all(rx_clean_all), .rx_ram_rd_byte(rx_ram_rd_byte),
      .rx_ram_rd_flags(rx_ram_rd_flags), .rx_ram_lost(rx_ram_lost),
      .rx_pending(rx_pending), .pkt_size(pkt_size)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ram_fn(input int ch, input logic [ADDR_W-1:0] a);
      return a[7:0] ^ {a[9:8], 6'b000000} ^ ((ch == 1) ? 8'h3C : 8'hC3);
   endfunction

   // External RAM model: one-cycle registered read latency per channel.
   always @(posedge clk) begin
      rx_ram_rd_byte[7:0]  <= ram_fn(0, rx_ram_rd_addr);
      rx_ram_rd_byte[15:8] <= ram_fn(1, rx_ram_rd_addr);
   end

   always @(negedge clk) if (rx_ram_rd_done != '0) mon_done++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [7:0] d, input logic [1:0] lost);
      @(negedge clk);
      csr_address = a; csr_writedata = d; csr_write = 1'b1; rx_ram_lost = lost;
      @(negedge clk);
      csr_write = 1'b0; rx_ram_lost = '0;
      $display("WR addr=0x%02h data=0x%02h", a, d);
   endtask

   task automatic bus_read(input logic [4:0] a, input logic [7:0] exp, input string name,
                           input logic [1:0] lost);
      logic [7:0] e;
      exp_q.push_back(exp);
      @(negedge clk);
      csr_address = a; csr_read = 1'b1; rx_ram_lost = lost;
      #1;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         check(name, csr_readdata, e);
         $display("RD addr=0x%02h data=0x%02h exp=0x%02h", a, csr_readdata, e);
      end
      @(negedge clk);
      csr_read = 1'b0; rx_ram_lost = '0;
   endtask

   task automatic cs_toggle();
      @(negedge clk); chip_select = 1'b0;
      @(negedge clk); chip_select = 1'b1;
   endtask

   typedef struct {
      logic       wr;
      logic [4:0] a;
      logic [7:0] d;
      string      name;
   } vec_t;

   vec_t vecs[23];
   int   cnt;
   int   bad;
   int   done_before;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // For reads, d holds the expected value.
      vecs[0]  = '{1'b0, 5'h00, 8'h20, "version"};
      vecs[1]  = '{1'b0, 5'h04, 8'hF9, "pkt_size_rst"};
      vecs[2]  = '{1'b0, 5'h02, 8'h80, "setting_rst"};
      vecs[3]  = '{1'b0, 5'h11, 8'h00, "int_mask_rst"};
      vecs[4]  = '{1'b0, 5'h10, 8'h00, "int_flag_rst"};
      vecs[5]  = '{1'b0, 5'h1C, 8'h00, "lost_cnt_rst"};
      vecs[6]  = '{1'b0, 5'h03, 8'h00, "unused_rd"};
      vecs[7]  = '{1'b1, 5'h04, 8'h3F, "wr_pkt"};
      vecs[8]  = '{1'b0, 5'h04, 8'h3F, "pkt_size_wr"};
      vecs[9]  = '{1'b1, 5'h02, 8'h03, "wr_setting_clamp"};
      vecs[10] = '{1'b0, 5'h02, 8'h01, "setting_clamp"};
      vecs[11] = '{1'b1, 5'h18, 8'h12, "wr_addr_lo"};
      vecs[12] = '{1'b1, 5'h1A, 8'hFF, "wr_addr_hi"};
      vecs[13] = '{1'b0, 5'h18, 8'h12, "addr_lo"};
      vecs[14] = '{1'b0, 5'h1A, 8'h03, "addr_hi_trunc"};
      vecs[15] = '{1'b1, 5'h02, 8'h00, "wr_setting_ch0"};
      vecs[16] = '{1'b0, 5'h18, 8'h00, "chsel_clr_lo"};
      vecs[17] = '{1'b0, 5'h1A, 8'h00, "chsel_clr_hi"};
      vecs[18] = '{1'b1, 5'h02, 8'h81, "wr_setting_ch1"};
      vecs[19] = '{1'b0, 5'h02, 8'h81, "setting_ch1"};
      vecs[20] = '{1'b1, 5'h05, 8'hAA, "wr_unused"};
      vecs[21] = '{1'b0, 5'h05, 8'h00, "unused_ignored"};
      vecs[22] = '{1'b0, 5'h04, 8'h3F, "pkt_unchanged"};

      reset_n = 1'b0; chip_select = 1'b0; csr_address = '0; csr_read = 1'b0;
      csr_write = 1'b0; csr_writedata = '0; rx_ram_lost = '0; rx_pending = '0;
      rx_ram_rd_flags = '0;
      repeat (3) @(negedge clk);
      check("rst_pkt_size_in_reset", pkt_size, 8'd249);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_irq", irq, 1'b0);
      check("rst_rd_done", rx_ram_rd_done, 2'b00);
      check("rst_clean", rx_clean_all, 2'b00);
      check("rst_pkt_size", pkt_size, 8'd249);
      check("rst_addr", rx_ram_rd_addr, 10'd0);
      check("rst_ch_sel", rx_ch_sel, 2'd0);

      chip_select = 1'b1;
      for (int i = 0; i < 23; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d, 2'b00);
         else            bus_read(vecs[i].a, vecs[i].d, vecs[i].name, 2'b00);
      end
      check("pkt_size_port", pkt_size, 8'h3F);
      check("ch_sel_port", rx_ch_sel, 2'd1);

      // Channel-1 read-out with auto-increment, then auto-release on chip_select fall.
      for (int k = 0; k < 3; k++)
         bus_read(5'h14, ram_fn(1, 10'(k)), $sformatf("rx_byte%0d", k), 2'b00);
      check("addr_after_3", rx_ram_rd_addr, 10'd3);
      @(negedge clk); chip_select = 1'b0;
      cnt = 0; bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (rx_ram_rd_done == 2'b10) cnt++;
         else if (rx_ram_rd_done != 2'b00) bad++;
      end
      check("auto_done_width", cnt, 1);
      check("auto_done_other", bad, 0);
      check("auto_done_addr", rx_ram_rd_addr, 10'd0);
      chip_select = 1'b1;

      // Lost flag: set, interrupt, clear-vs-set race, clear.
      bus_write(5'h11, 8'h10, 2'b00);
      @(negedge clk); chip_select = 1'b0;
      @(negedge clk); rx_ram_lost = 2'b01;
      @(negedge clk); rx_ram_lost = 2'b00;
      #1 check("irq_lost", irq, 1'b1);
      @(negedge clk); chip_select = 1'b1;
      bus_read(5'h10, 8'h10, "int_flag_lost", 2'b01);
      check("irq_after_race", irq, 1'b1);
      cs_toggle();
      bus_read(5'h10, 8'h10, "int_flag_kept", 2'b00);
      check("irq_cleared", irq, 1'b0);
      cs_toggle();
      bus_read(5'h10, 8'h00, "int_flag_clear", 2'b00);
      rx_pending = 2'b10;
      cs_toggle();
      bus_read(5'h10, 8'h02, "int_flag_pending", 2'b00);
      check("irq_pending_masked", irq, 1'b0);
      rx_pending = 2'b00;

      // Address wrap gives address 0 with no release strobe.
      done_before = mon_done;
      bus_write(5'h1A, 8'h03, 2'b00);
      bus_write(5'h18, 8'hFF, 2'b00);
      bus_read(5'h14, ram_fn(1, 10'h3FF), "rx_byte_3ff", 2'b00);
      bus_read(5'h18, 8'h00, "wrap_lo", 2'b00);
      bus_read(5'h1A, 8'h00, "wrap_hi", 2'b00);
      check("wrap_no_done", mon_done, done_before);

      // RX_CTRL strobes.
      bus_write(5'h16, 8'h20, 2'b00);
      #1 check("clean_all", rx_clean_all, 2'b11);
      check("clean_all_no_done", rx_ram_rd_done, 2'b00);
      @(negedge clk) check("clean_all_end", rx_clean_all, 2'b00);
      bus_write(5'h16, 8'h12, 2'b00);
      #1 check("ctrl_done", rx_ram_rd_done, 2'b10);
      check("ctrl_clean_sel", rx_clean_all, 2'b10);
      @(negedge clk);
      check("ctrl_done_end", rx_ram_rd_done, 2'b00);
      check("ctrl_clean_end", rx_clean_all, 2'b00);
      bus_write(5'h18, 8'h55, 2'b00);
      bus_write(5'h16, 8'h01, 2'b00);
      bus_read(5'h18, 8'h00, "ctrl_addr_clr", 2'b00);

      // Page flag shift on channel 0.
      bus_write(5'h02, 8'h80, 2'b00);
      check("ch_sel0_port", rx_ch_sel, 2'd0);
      rx_ram_rd_flags = {16'h1234, 16'hA55A};
      cs_toggle();
      bus_read(5'h19, 8'h5A, "flag_b0", 2'b00);
      bus_read(5'h19, 8'hA5, "flag_b1", 2'b00);
      bus_read(5'h19, 8'h00, "flag_b2", 2'b00);

`ifdef CAM_CSR_LOST_CNT_EN
      bus_write(5'h02, 8'h81, 2'b00);
      @(negedge clk); rx_ram_lost = 2'b10;
      repeat (300) @(negedge clk);
      rx_ram_lost = 2'b00;
      bus_read(5'h1C, 8'hFF, "lost_cnt_sat", 2'b00);
      bus_write(5'h1C, 8'h00, 2'b10);
      bus_read(5'h1C, 8'h01, "lost_cnt_race", 2'b00);
      bus_write(5'h1C, 8'h00, 2'b00);
      bus_read(5'h1C, 8'h00, "lost_cnt_clr", 2'b00);
`else
      bus_write(5'h1C, 8'h77, 2'b00);
      bus_read(5'h1C, 8'h00, "lost_cnt_absent", 2'b00);
`endif

      // Reset during a pending auto-release: no strobe, registers back to defaults.
      bus_write(5'h02, 8'h80, 2'b00);
      bus_write(5'h18, 8'h07, 2'b00);
      done_before = mon_done;
      @(negedge clk); chip_select = 1'b0; reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_done", mon_done, done_before);
      check("abort_addr", rx_ram_rd_addr, 10'd0);
      check("abort_pkt_size", pkt_size, 8'd249);
      check("abort_irq", irq, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cam_csr_mc.md
# cam_csr_mc

Multi-channel CPU-side control/status register block for the camera packet receiver. It sits between the SPI/parallel CSR bus slave and CH_NUM independent RX page RAMs. It provides:
- packet-size configuration;
- interrupt flag and mask handling;
- per-channel page read-out with auto-increment address and flag shifting;
- per-channel page release and clean strobes.

## Interface
Parameters:
- VERSION, 8'h20, value returned by the VERSION register
- CH_NUM, 2, number of RX channels, legal 1..4
- ADDR_W, 8, RX RAM read address width, legal 8..12
- FLAG_W, 16, page flag width per channel, multiple of 8, max 32

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- irq  out  1  high while (int_flag & int_mask) != 0
- chip_select  in  1  high during a bus transaction
- csr_address  in  5  register address
- csr_read  in  1  one-cycle read strobe
- csr_readdata  out  8  combinational read data
- csr_write  in  1  one-cycle write strobe
- csr_writedata  in  8  write data
- rx_ch_sel  out  2  selected channel, drives external RAM mux
- rx_ram_rd_addr  out  ADDR_W  read address into the selected channel's RAM
- rx_ram_rd_done  out  CH_NUM  one-cycle page-release strobe per channel
- rx_clean_all  out  CH_NUM  one-cycle flush strobe per channel
- rx_ram_rd_byte  in  CH_NUM*8  per-channel RAM data, channel n at [8n+7:8n]
- rx_ram_rd_flags  in  CH_NUM*FLAG_W  per-channel page flags
- rx_ram_lost  in  CH_NUM  one-cycle packet-lost pulse per channel
- rx_pending  in  CH_NUM  level: channel has a complete page
- pkt_size  out  8  packet size minus 1

## Operation
Register map (unused addresses read 0; writes to them are ignored):
- 0x00 VERSION, read-only.
- 0x02 SETTING, read/write, reset 0x80.
  - [1:0] ch_sel; values >= CH_NUM are clamped to CH_NUM-1 on write.
  - [7] auto_done.
- 0x04 PKT_SIZE, read/write, reset 249.
- 0x10 INT_FLAG, read-only snapshot.
  - [3:0] rx_pending per channel.
  - [7:4] lost flag per channel.
  - Bits for channels >= CH_NUM read 0.
- 0x11 INT_MASK, read/write, reset 0.
- 0x14 RX: rx_ram_rd_byte of the selected channel. Each read increments rx_ram_rd_addr modulo 2^ADDR_W.
- 0x16 RX_CTRL, write-only; the bits act independently.
  - bit0: rx_ram_rd_addr <= 0.
  - bit1: rd_done strobe for the selected channel.
  - bit4: clean strobe for the selected channel.
  - bit5: clean strobe for all channels.
- 0x18 RX_ADDR_LO, read/write: rx_ram_rd_addr[7:0].
- 0x19 RX_PAGE_FLAG: low byte of the flag shift register. Each read shifts it right 8 bits, zero-filled.
- 0x1A RX_ADDR_HI, read/write: rx_ram_rd_addr[ADDR_W-1:8]; reads 0 when ADDR_W = 8.
- 0x1C LOST_CNT: see Configuration.

Behaviour:
- Snapshots: while chip_select is low, every cycle:
  - int_flag_snapshot <= live int_flag;
  - flag shift register <= rx_ram_rd_flags of the selected channel.
  - Both hold while chip_select is high.
- Lost flags:
  - Set by rx_ram_lost[n].
  - A read of INT_FLAG clears only the lost bits that were 1 in the snapshot.
  - A lost pulse in the same cycle as the clearing read wins: the flag stays 1.
- irq uses the live int_flag, not the snapshot.
- Auto release: on the cycle after a chip_select falling edge, if auto_done = 1 and rx_ram_rd_addr != 0, then rx_ram_rd_done[ch_sel] pulses and rx_ram_rd_addr <= 0.
- Changing ch_sel resets rx_ram_rd_addr to 0.
- Address-update priority, highest first:
  1. RX_CTRL bit0 or an RX_ADDR write
  2. auto-release reset
  3. RX read increment
- Strobe outputs default to 0 every cycle.

## Timing
- csr_readdata is combinational from csr_address and the current state; zero cycles.
- All register updates, strobes and increments take effect on the clk edge where the strobe is sampled, and are visible on the next cycle.
- rx_ram_rd_byte must be valid one cycle after the rx_ram_rd_addr change. This is the external RAM's registered latency; the bus reads no faster than every 2 cycles.
- rx_ram_rd_done / rx_clean_all are exactly 1 cycle wide.
- Reset values:
  - all outputs 0, except pkt_size = 249;
  - SETTING = 0x80, snapshot = 0, lost flags = 0.
- Reset asserted mid-transaction aborts it with no strobe, including a pending auto-release.
- Address wrap: from 2^ADDR_W-1 to 0, with no flag and no done strobe.

## Configuration
- CAM_CSR_LOST_CNT_EN defined:
  - Per-channel 8-bit saturating counter, incremented on rx_ram_lost[n] and stuck at 255.
  - 0x1C reads the selected channel's counter.
  - A write of any value to 0x1C clears the selected channel's counter.
  - A simultaneous lost pulse and clear yields 1.
- Not defined: no counters; 0x1C reads 0 and writes are ignored.

## Test plan
- Reset, no stimulus:
  - VERSION reads 0x20, PKT_SIZE 249, SETTING 0x80, INT_MASK 0, irq = 0, all strobes 0.
- CH_NUM = 2, ADDR_W = 10:
  - Set ch_sel = 1, raise chip_select, perform 3 RX reads, drop chip_select.
  - Bytes come from channel 1 at addresses 0, 1, 2.
  - rx_ram_rd_done = 2'b10 for exactly 1 cycle, then address = 0.
- rx_ram_lost[0] pulse with INT_MASK = 0x10:
  - irq = 1 and INT_FLAG reads 0x10.
  - A repeat lost pulse in the same cycle as the read leaves the flag at 1.
  - The next read after chip_select toggles returns 0x10; a further read clears it and irq = 0.
- Address wrap:
  - Write ADDR_HI = 0x03 and ADDR_LO = 0xFF, then RX read; address becomes 0.
  - Write RX_CTRL = 0x20; rx_clean_all = 2'b11 for 1 cycle.
- Page flags:
  - With rx_ram_rd_flags channel 0 = 0xA55A, under one chip_select, two PAGE_FLAG reads return 0x5A then 0xA5; a third returns 0x00.
- With CAM_CSR_LOST_CNT_EN:
  - 300 lost pulses on channel 1: LOST_CNT reads 255.
  - Write 0x1C together with a lost pulse: it reads 1.
